// File: rtl/kremap_sequencer.sv
// k-space remap sequencer: forwards samples one cycle late and flags the table-selected ones with their fraction.
// Table read latency 1 cycle; prefetch on each hit keeps back-to-back indices triggerable. No backpressure.
module kremap_sequencer #(
  parameter int WIDTH       = 16,
  parameter int FRACTIONBIT = 15,
  parameter int IDXW        = 12,
  parameter int TABLE_DEPTH = 2048,
  localparam int AW         = $clog2(TABLE_DEPTH),
  localparam int FW         = FRACTIONBIT + 1,
  localparam int EW         = IDXW + FW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [EW-1:0]    cfg_wdata,
  input  logic [AW:0]      cfg_num,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [FW-1:0]    o_fraction,
  output logic             o_trigger,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem [TABLE_DEPTH];
  logic [EW-1:0]     ent_q;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW:0]       num_q, num_d;
  logic [IDXW-1:0]   scnt_q, scnt_d, prev_q, prev_d;
  logic              pend_q, pend_d, err_q, err_d, done_q, done_d, trig_q, trig_d;
  logic [FW-1:0]     frac_q, frac_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              ram_we, ram_re, hit, skip, last;
  logic [AW-1:0]     ram_addr;
  logic [IDXW-1:0]   cur_idx;
  logic [FW-1:0]     cur_frac;

  // The RAM output register doubles as the current entry; it only changes on a read.
  assign cur_idx  = ent_q[EW-1:FW];
  assign cur_frac = ent_q[FW-1:0];
  assign last     = ({1'b0, ptr_q} == (num_q - (AW+1)'(1)));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    num_d    = num_q;
    scnt_d   = scnt_q;
    prev_d   = prev_q;
    pend_d   = pend_q;
    err_d    = err_q;
    done_d   = 1'b0;
    trig_d   = 1'b0;
    frac_d   = '0;
    data_d   = i_valid ? i_data : data_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = cfg_addr;
    hit      = 1'b0;
    skip     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          // deferred arm: the write issued alongside start has landed, now fetch entry 0
          ram_re   = 1'b1;
          ram_addr = '0;
          pend_d   = 1'b0;
          state_d  = S_ARMED;
        end else begin
          ram_we = cfg_we;
          if (!cfg_we) ram_addr = '0;
          if (start) begin
            err_d = (cfg_num == '0);
            if (cfg_num != '0) begin
              num_d = cfg_num;
              ptr_d = '0;
              if (cfg_we) begin
                pend_d = 1'b1;
              end else begin
                ram_re  = 1'b1;
                state_d = S_ARMED;
              end
            end
          end
        end
      end
      S_ARMED: begin
        scnt_d  = '0;
        prev_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (done_q) begin
          state_d = S_IDLE;
        end else begin
          if (i_valid) begin
            if (scnt_q == '1) err_d = 1'b1;
            else              scnt_d = scnt_q + IDXW'(1);
          end
          // prev_q starts at 0, so this also rejects idx == 0
          if (cur_idx <= prev_q) begin
            skip  = 1'b1;
            err_d = 1'b1;
          end else if (i_valid && scnt_q == cur_idx) begin
            hit = 1'b1;
          end
          if (hit || skip) begin
            if (last) begin
              if (hit) done_d = 1'b1;
              else     state_d = S_IDLE;
            end else begin
              ptr_d    = ptr_q + AW'(1);
              ram_re   = 1'b1;
              ram_addr = ptr_q + AW'(1);
            end
          end
          if (hit) begin
            prev_d = cur_idx;
            trig_d = 1'b1;
            frac_d = cur_frac;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      err_d   = err_q;
      done_d  = 1'b0;
      trig_d  = 1'b0;
      frac_d  = '0;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      num_q   <= '0;
      scnt_q  <= '0;
      prev_q  <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      trig_q  <= 1'b0;
      frac_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      num_q   <= num_d;
      scnt_q  <= scnt_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      done_q  <= done_d;
      trig_q  <= trig_d;
      frac_q  <= frac_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= cfg_wdata;
    if (ram_re) ent_q <= mem[ram_addr];
  end

  assign o_data     = data_q;
  assign o_fraction = frac_q;
  assign o_trigger  = trig_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/kremap_sequencer.md
Name: kremap_sequencer

Overview:
- Controller that drives the linear-interpolation remapping datapath for one A-line at a time.
- Holds a programmable k-space remap table. Each entry gives the input sample index at which an output point is produced, plus its fractional weight.
- Streams incoming samples through to the datapath with a one-cycle delay.
- Asserts trigger and supplies the fraction on exactly the samples named by the table.
- Sits between the ADC sample stream and the interpolator; software loads the table between lines.

Parameters:
- WIDTH, 16, sample width.
- FRACTIONBIT, 15, fraction LSBs; the fraction field is FRACTIONBIT+1 bits (unsigned, 1.0 = 1<<FRACTIONBIT).
- IDXW, 12, input sample index width.
- TABLE_DEPTH, 2048, remap table entries (power of 2); AW = log2(TABLE_DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_we  in  1  table write strobe, honoured only in IDLE.
- cfg_addr  in  AW  table write address.
- cfg_wdata  in  IDXW+FRACTIONBIT+1  entry: {idx, frac}.
- cfg_num  in  AW+1  number of valid entries (1..TABLE_DEPTH), sampled on start.
- start  in  1  arm for next line, honoured only in IDLE.
- abort  in  1  return to IDLE immediately.
- i_data  in  WIDTH  input sample.
- i_valid  in  1  input sample strobe; at most one sample per cycle, no backpressure.
- o_data  out  WIDTH  sample forwarded to the datapath.
- o_fraction  out  FRACTIONBIT+1  weight for the current sample.
- o_trigger  out  1  produce an interpolated point on this sample.
- busy  out  1  high in ARMED/RUN.
- done  out  1  one-cycle pulse when the last entry has been triggered.
- err  out  1  sticky error; cleared by start or rst.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, table contents undefined (not reset).
- Table: single-port synchronous RAM, registered read (1-cycle latency). Writes are ignored outside IDLE.
- States:
  - IDLE: start -> ARMED; latch num = cfg_num; ptr = 0; issue read of entry 0; clear err. If cfg_num == 0: set err, stay in IDLE.
  - ARMED: one cycle; capture entry 0 into cur_idx/cur_frac -> RUN; sample counter scnt = 0.
  - RUN: on each i_valid: scnt increments (saturates at 2^IDXW-1, setting err on saturation).
    - hit = i_valid && scnt == cur_idx.
    - On hit: issue read of ptr+1 in the same cycle; load cur_* the next cycle; ptr++.
    - When ptr reaches num-1 on a hit: done pulse on the cycle o_trigger is asserted, then -> IDLE.
- Output timing: a sample accepted at cycle t appears on o_data at t+1.
  - o_trigger is 1 at t+1 iff that sample was a hit; o_fraction = cur_frac at t+1, else 0.
  - o_data holds its last value when there is no i_valid.
  - o_trigger is 0 outside RUN.
- Table rules: entry indices must be >= 1 (the previous sample is needed) and strictly increasing. An entry that violates either rule is skipped, ptr advances, and err is set.
  - Skip detection is in RUN when the entry is loaded: idx == 0, or idx <= index of the previous hit.
  - A skip costs one cycle; no hit is possible in that cycle, so that sample's trigger is lost and err flags it.
- Back-to-back hits (idx, idx+1 on consecutive cycles) must be supported: the prefetch is read in the hit cycle and compared the next cycle.
- Simultaneous events:
  - abort has priority over everything: -> IDLE next cycle, no done, err unchanged.
  - start while busy is ignored.
  - cfg_we and start in the same IDLE cycle: the write completes, then arm.
  - rst mid-line: immediate IDLE with outputs 0.
- Fraction values > 1<<FRACTIONBIT are passed through unchecked; the datapath clamps.

Test Plan:
- Load 3 entries {1,0x4000},{2,0x2000},{5,0x7FFF}, num=3, start, then stream samples 10,20,…,80 on consecutive cycles -> o_trigger high on samples 20, 30, 60 with fractions 0x4000, 0x2000, 0x7FFF; done coincides with the 60 trigger; busy falls the next cycle.
- Same table, i_valid gapped (1 valid every 3 cycles) -> identical trigger/fraction sequence; o_data holds between samples.
- Table {0,x},{3,x},{3,x},{4,0x100}, num=4 -> entries 0 and 3-duplicate skipped; triggers at sample 3 and sample 4 (fraction 0x100); err=1 after the line; next start clears err.
- abort asserted after the first trigger -> busy 0 next cycle, no done, no further o_trigger on subsequent samples.
- cfg_we pulses during RUN to address 0, then rerun the line -> original entry 0 behaviour unchanged (the write was ignored).
- rst asserted mid-line -> all outputs 0 asynchronously; after release, start with cfg_num=0 -> err=1, busy stays 0.
